pulse_recover: RTL and testbench
================================

Name: pulse_recover

Overview:
- Inverse of the pulse-stretch debug path: takes a slow, asynchronous, possibly glitchy level input (slow pin, logic-analyser loopback, button, slow-domain flag) and recovers clean single events in the fast `clk` domain.
- Datapath: two-flop synchroniser, minimum-width glitch filter, then a fixed-width `O_fast` pulse per qualified rising edge.
- An optional saturating event counter feeds the register map.

Parameters:
- pFILTER_CYCLES, 4, consecutive synchronised samples needed to accept a level change; legal range 1..255.
- pPULSE_WIDTH, 1, `O_fast` high time in `clk` cycles; legal range 1..255.
- pCOUNT_WIDTH, 16, width of `O_count`.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- I_slow  input  1  asynchronous slow level input.
- I_clear  input  1  synchronous clear of `O_count`.
- O_fast  output  1  recovered pulse, registered.
- O_level  output  1  filtered level of `I_slow`, registered.
- O_busy  output  1  high in any state other than IDLE.
- O_count  output  pCOUNT_WIDTH  recovered-event count.

Behaviour:
- Reset (async, active-high): sync flops=0, state=IDLE, qcnt=0, pcnt=0, O_fast=0, O_level=0, O_busy=0, O_count=0. Takes effect immediately, including mid-pulse (O_fast drops at once).
- Synchroniser: s = I_slow after 2 flops. Only s is used downstream.
- FSM states: IDLE, QUAL_HIGH, PULSE, HIGH, QUAL_LOW. 8-bit qcnt counts consecutive samples; 8-bit pcnt counts pulse cycles.
- IDLE:
  - s=1 and pFILTER_CYCLES=1: go to PULSE.
  - s=1 otherwise: go to QUAL_HIGH, qcnt=1.
- QUAL_HIGH:
  - s=0: go to IDLE, qcnt=0 (glitch rejected, no output).
  - s=1 and qcnt=pFILTER_CYCLES-1: go to PULSE.
  - Otherwise qcnt++.
- PULSE:
  - On entry: O_fast<=1, O_level<=1, pcnt=1.
  - s is ignored in this state.
  - When pcnt=pPULSE_WIDTH: go to HIGH, O_fast<=0. Otherwise pcnt++.
- HIGH: s=0 goes to QUAL_LOW with qcnt=1, or straight to IDLE if pFILTER_CYCLES=1.
- QUAL_LOW:
  - s=1: go to HIGH, qcnt=0.
  - s=0 and qcnt=pFILTER_CYCLES-1: go to IDLE, O_level<=0.
  - Otherwise qcnt++.
- Latency: with edge 1 as the first edge sampling I_slow=1, O_fast is high after edge pFILTER_CYCLES+2 for exactly pPULSE_WIDTH cycles.
- Event rules:
  - A falling edge never produces a pulse.
  - Exactly one pulse per qualified rising edge.
  - A rising edge during PULSE/HIGH is not a new event. Input must qualify low first.
- After reset release with I_slow held high, the filtered level is 0, so one pulse is produced after normal latency.
- O_busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: PULSE_RECOVER_COUNT_EN.
- Defined:
  - O_count increments on each PULSE entry and saturates at all-ones.
  - I_clear sets it to 0.
  - I_clear coincident with an increment sets it to 1, so no event is lost.
- Undefined: counter logic omitted, O_count tied to 0, I_clear ignored. The port list is unchanged.

Decomposition:
- Shared package pulse_recover_pkg: FSM state encodings (3-bit localparams) and the 8-bit qcnt/pcnt width constant.
- One natural sub-module, sync_2ff: a 2-flop synchroniser with async active-high reset, reusable elsewhere.
- FSM and counter stay in pulse_recover.

Test Plan:
- Defaults (F=4, W=1). I_slow rises before edge 1, held 20 cycles → O_fast high only after edge 6 for 1 cycle; O_level high from edge 6 until 4 samples after the synchronised fall; O_count=1.
- I_slow high for 3 cycles, then low → no O_fast pulse, O_level stays 0, FSM returns to IDLE, O_busy pulses then drops.
- W=5. Steady high, then a 2-cycle low glitch while in HIGH → single 5-cycle O_fast pulse, no second pulse, O_level stays 1.
- Assert reset mid-PULSE (W=8, cycle 3 of 8), release with I_slow still high → O_fast drops immediately; after release one new 8-cycle pulse after F+2 edges; O_count=1.
- Count feature on, pCOUNT_WIDTH=2: 5 qualified rising edges → O_count saturates at 3. I_clear in the same cycle as a PULSE entry → O_count=1.
- F=1, W=1: I_slow toggles every 4 cycles → one pulse per rising edge, each 3 edges after the input rises.

Source files
------------

// File: rtl/pulse_recover_pkg.sv
// Shared definitions for the pulse recovery path: FSM state encodings
// and the width of the qualification / pulse-length counters.
package pulse_recover_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_QUAL_HIGH = 3'd1;
  localparam logic [2:0] ST_PULSE     = 3'd2;
  localparam logic [2:0] ST_HIGH      = 3'd3;
  localparam logic [2:0] ST_QUAL_LOW  = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    QUAL_HIGH = ST_QUAL_HIGH,
    PULSE     = ST_PULSE,
    HIGH      = ST_HIGH,
    QUAL_LOW  = ST_QUAL_LOW
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, reset (async, active-high), d (async in), q (synchronised out).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pulse_recover.sv
// Recovers clean single-cycle-group events from a slow, glitchy level input.
// Ports: clk, reset (async, active-high), I_slow (async level), I_clear
// (sync count clear), O_fast (recovered pulse), O_level (filtered level),
// O_busy (FSM not idle), O_count (event count, only with
// PULSE_RECOVER_COUNT_EN; tied to 0 otherwise).
module pulse_recover #(
  parameter int pFILTER_CYCLES = 4,
  parameter int pPULSE_WIDTH   = 1,
  parameter int pCOUNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    I_slow,
  input  logic                    I_clear,
  output logic                    O_fast,
  output logic                    O_level,
  output logic                    O_busy,
  output logic [pCOUNT_WIDTH-1:0] O_count
);

  import pulse_recover_pkg::*;

  localparam logic [CNT_W-1:0] FLT_LAST = CNT_W'(pFILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] PW       = CNT_W'(pPULSE_WIDTH);
  localparam bit               FLT_ONE  = (pFILTER_CYCLES == 1);

  logic s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (I_slow),
    .q     (s)
  );

  state_t           state, state_n;
  logic [CNT_W-1:0] qcnt, qcnt_n;
  logic [CNT_W-1:0] pcnt, pcnt_n;
  logic             fast_n, level_n;
  logic             go;

  always_comb begin
    state_n = state;
    qcnt_n  = qcnt;
    pcnt_n  = pcnt;
    fast_n  = O_fast;
    level_n = O_level;
    go      = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          if (FLT_ONE) begin
            go = 1'b1;
          end else begin
            state_n = QUAL_HIGH;
            qcnt_n  = 8'd1;
          end
        end
      end
      QUAL_HIGH: begin
        if (!s) begin
          state_n = IDLE;
          qcnt_n  = '0;
        end else if (qcnt == FLT_LAST) begin
          go = 1'b1;
        end else begin
          qcnt_n = qcnt + 8'd1;
        end
      end
      PULSE: begin
        if (pcnt == PW) begin
          state_n = HIGH;
          fast_n  = 1'b0;
        end else begin
          pcnt_n = pcnt + 8'd1;
        end
      end
      HIGH: begin
        if (!s) begin
          if (FLT_ONE) begin
            state_n = IDLE;
            level_n = 1'b0;
          end else begin
            state_n = QUAL_LOW;
            qcnt_n  = 8'd1;
          end
        end
      end
      QUAL_LOW: begin
        if (s) begin
          state_n = HIGH;
          qcnt_n  = '0;
        end else if (qcnt == FLT_LAST) begin
          state_n = IDLE;
          level_n = 1'b0;
        end else begin
          qcnt_n = qcnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // PULSE entry from either qualifying path
    if (go) begin
      state_n = PULSE;
      fast_n  = 1'b1;
      level_n = 1'b1;
      pcnt_n  = 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      qcnt    <= '0;
      pcnt    <= '0;
      O_fast  <= 1'b0;
      O_level <= 1'b0;
      O_busy  <= 1'b0;
    end else begin
      state   <= state_n;
      qcnt    <= qcnt_n;
      pcnt    <= pcnt_n;
      O_fast  <= fast_n;
      O_level <= level_n;
      O_busy  <= (state_n != IDLE);
    end
  end

`ifdef PULSE_RECOVER_COUNT_EN
  logic [pCOUNT_WIDTH-1:0] count_q;

  // clear coincident with an event leaves that event counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (I_clear) begin
      count_q <= go ? pCOUNT_WIDTH'(1) : '0;
    end else if (go && (count_q != '1)) begin
      count_q <= count_q + pCOUNT_WIDTH'(1);
    end
  end

  assign O_count = count_q;
`else
  logic unused_cnt;
  assign unused_cnt = I_clear ^ go;
  assign O_count    = '0;
`endif

endmodule

// File: tb/tb_pulse_recover.sv
// Directed bench for pulse_recover across four parameter sets.
// Count expectations follow PULSE_RECOVER_COUNT_EN.
module tb_pulse_recover;

`ifdef PULSE_RECOVER_COUNT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;
  logic slow0, slow1, slow2, slow3;
  logic clr0, clr1, clr2, clr3;
  logic fast0, fast1, fast2, fast3;
  logic lvl0, lvl1, lvl2, lvl3;
  logic busy0, busy1, busy2, busy3;
  logic [15:0] cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;

  int checks = 0;
  int errors = 0;

  pulse_recover #(.pFILTER_CYCLES(4), .pPULSE_WIDTH(1), .pCOUNT_WIDTH(16)) u0 (
    .clk(clk), .reset(rst), .I_slow(slow0), .I_clear(clr0),
    .O_fast(fast0), .O_level(lvl0), .O_busy(busy0), .O_count(cnt0));

  pulse_recover #(.pFILTER_CYCLES(4), .pPULSE_WIDTH(5), .pCOUNT_WIDTH(16)) u1 (
    .clk(clk), .reset(rst), .I_slow(slow1), .I_clear(clr1),
    .O_fast(fast1), .O_level(lvl1), .O_busy(busy1), .O_count(cnt1));

  pulse_recover #(.pFILTER_CYCLES(4), .pPULSE_WIDTH(8), .pCOUNT_WIDTH(16)) u2 (
    .clk(clk), .reset(rst2), .I_slow(slow2), .I_clear(clr2),
    .O_fast(fast2), .O_level(lvl2), .O_busy(busy2), .O_count(cnt2));

  pulse_recover #(.pFILTER_CYCLES(1), .pPULSE_WIDTH(1), .pCOUNT_WIDTH(2)) u3 (
    .clk(clk), .reset(rst), .I_slow(slow3), .I_clear(clr3),
    .O_fast(fast3), .O_level(lvl3), .O_busy(busy3), .O_count(cnt3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    slow0 = 0; slow1 = 0; slow2 = 0; slow3 = 0;
    clr0 = 0; clr1 = 0; clr2 = 0; clr3 = 0;
    tick();
    tick();
    chk("rst_fast", 32'(fast0), 0);
    chk("rst_level", 32'(lvl0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_count", 32'(cnt0), 0);
    rst = 1'b0; rst2 = 1'b0;

    // basic latency: pulse after edge 6
    slow0 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("t1_fast_e%0d", e), 32'(fast0), 32'(e == 6));
      chk($sformatf("t1_lvl_e%0d", e), 32'(lvl0), 32'(e >= 6));
      chk($sformatf("t1_busy_e%0d", e), 32'(busy0), 32'(e >= 3));
    end
    repeat (12) tick();
    slow0 = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("t1f_fast_e%0d", e), 32'(fast0), 0);
      chk($sformatf("t1f_lvl_e%0d", e), 32'(lvl0), 32'(e < 6));
      chk($sformatf("t1f_busy_e%0d", e), 32'(busy0), 32'(e < 6));
    end
    chk("t1_count", 32'(cnt0), 32'(CEN));

    // 3-cycle glitch high: rejected
    slow0 = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) slow0 = 1'b0;
      tick();
      chk($sformatf("t2_fast_e%0d", e), 32'(fast0), 0);
      chk($sformatf("t2_lvl_e%0d", e), 32'(lvl0), 0);
      chk($sformatf("t2_busy_e%0d", e), 32'(busy0), 32'(e >= 3 && e <= 5));
    end
    chk("t2_count", 32'(cnt0), 32'(CEN));

    // W=5 pulse, then 2-cycle low glitch while HIGH
    slow1 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk($sformatf("t3_fast_e%0d", e), 32'(fast1), 32'(e >= 6 && e <= 10));
    end
    slow1 = 1'b0;
    tick();
    tick();
    slow1 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk($sformatf("t3g_fast_e%0d", e), 32'(fast1), 0);
      chk($sformatf("t3g_lvl_e%0d", e), 32'(lvl1), 1);
    end
    chk("t3_count", 32'(cnt1), 32'(CEN));

    // W=8, reset in pulse cycle 3, release with input high
    slow2 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("t4_fast_e%0d", e), 32'(fast2), 32'(e >= 6));
    end
    #2 rst2 = 1'b1;
    #1;
    chk("t4_rst_fast", 32'(fast2), 0);
    chk("t4_rst_lvl", 32'(lvl2), 0);
    chk("t4_rst_busy", 32'(busy2), 0);
    @(negedge clk);
    rst2 = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk($sformatf("t4r_fast_e%0d", e), 32'(fast2), 32'(e >= 6 && e <= 13));
    end
    chk("t4_lvl", 32'(lvl2), 1);
    chk("t4_count", 32'(cnt2), 32'(CEN));

    // F=1: toggle every 4 cycles, count saturates at 3
    for (int e = 1; e <= 40; e++) begin
      slow3 = (((e - 1) / 4) % 2) == 0;
      tick();
      chk($sformatf("t5_fast_e%0d", e), 32'(fast3), 32'(e % 8 == 3));
      chk($sformatf("t5_lvl_e%0d", e), 32'(lvl3),
          32'((e % 8 >= 3) && (e % 8 <= 6)));
    end
    chk("t5_count_sat", 32'(cnt3), CEN ? 32'd3 : 32'd0);

    // clear with coincident event, then plain clear
    for (int e = 41; e <= 48; e++) begin
      slow3 = (((e - 1) / 4) % 2) == 0;
      clr3 = (e == 43) || (e == 45);
      tick();
      chk($sformatf("t6_fast_e%0d", e), 32'(fast3), 32'(e % 8 == 3));
      if (e == 43) chk("t6_clr_inc", 32'(cnt3), 32'(CEN));
      if (e == 45) chk("t6_clr", 32'(cnt3), 0);
    end
    clr3 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
